// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command host: command encodings, FSM states,
// protocol opcodes and the per-command TX/reply byte counts.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_WR      = 2'b00,
    CMD_RD      = 2'b01,
    CMD_ALU_OPS = 2'b10,
    CMD_ALU     = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU     = 8'hDD;

  localparam logic [2:0] TX_LEN_WR      = 3'd3;
  localparam logic [2:0] TX_LEN_RD      = 3'd2;
  localparam logic [2:0] TX_LEN_ALU_OPS = 3'd4;
  localparam logic [2:0] TX_LEN_ALU     = 3'd2;

  localparam logic [1:0] RSP_LEN_WR      = 2'd0;
  localparam logic [1:0] RSP_LEN_RD      = 2'd1;
  localparam logic [1:0] RSP_LEN_ALU_OPS = 2'd2;
  localparam logic [1:0] RSP_LEN_ALU     = 2'd2;

  function automatic logic [2:0] tx_len(input cmd_type_e t);
    case (t)
      CMD_WR:      return TX_LEN_WR;
      CMD_RD:      return TX_LEN_RD;
      CMD_ALU_OPS: return TX_LEN_ALU_OPS;
      default:     return TX_LEN_ALU;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      CMD_WR:      return RSP_LEN_WR;
      CMD_RD:      return RSP_LEN_RD;
      CMD_ALU_OPS: return RSP_LEN_ALU_OPS;
      default:     return RSP_LEN_ALU;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_host_if.sv
// Command, TX byte, RX byte and response signals of the UART command host.
// The host block uses the slave modport; the sequencer/UART side uses master.
interface uart_cmd_host_if #(
  parameter int D_WIDTH  = 8,
  parameter int ADDRESS  = 4,
  parameter int FUNC_ALU = 4
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_type;
  logic [ADDRESS-1:0]     cmd_addr;
  logic [D_WIDTH-1:0]     cmd_wdata;
  logic [D_WIDTH-1:0]     cmd_opb;
  logic [FUNC_ALU-1:0]    cmd_func;
  logic [D_WIDTH-1:0]     tx_p_data;
  logic                   tx_d_vld;
  logic                   tx_ready;
  logic [D_WIDTH-1:0]     rx_p_data;
  logic                   rx_d_vld;
  logic [2*D_WIDTH-1:0]   resp_data;
  logic                   resp_valid;
  logic                   resp_timeout;
  logic                   busy;

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opb, cmd_func,
    input  tx_ready, rx_p_data, rx_d_vld,
    output cmd_ready, tx_p_data, tx_d_vld, resp_data, resp_valid, resp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opb, cmd_func,
    output tx_ready, rx_p_data, rx_d_vld,
    input  cmd_ready, tx_p_data, tx_d_vld, resp_data, resp_valid, resp_timeout, busy
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Reply timeout counter: clears on request, counts while enabled, and flags the cycle
// on which the count sits at TIMEOUT_CYC-1 without a clear.
module uart_cmd_timer #(
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // A clear in the threshold cycle means a byte arrived, which takes priority.
  assign expire = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: serialises one command onto TX and assembles its reply from RX.
// Define STRAY_CNT_EN to add stray_cnt, a saturating count of RX bytes seen outside WAIT_RSP.
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int D_WIDTH     = 8,
  parameter int ADDRESS     = 4,
  parameter int FUNC_ALU    = 4,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
`ifdef STRAY_CNT_EN
  output logic [7:0] stray_cnt,
`endif
  uart_cmd_host_if.slave bus
);

  state_e               state, state_nxt;
  cmd_type_e            type_q;
  logic [ADDRESS-1:0]   addr_q;
  logic [D_WIDTH-1:0]   wdata_q, opb_q, tx_byte;
  logic [FUNC_ALU-1:0]  func_q;
  logic [1:0]           tx_idx;
  logic                 rx_idx;
  logic [2*D_WIDTH-1:0] resp_q;
  logic                 ready_q, valid_q, timeout_q;
  logic                 accept, tx_fire, tx_last, rx_take, rx_last, expire;

  assign accept  = bus.cmd_valid && ready_q;
  assign tx_fire = (state == SEND) && bus.tx_ready;
  assign tx_last = {1'b0, tx_idx} == (tx_len(type_q) - 3'd1);
  assign rx_take = (state == WAIT_RSP) && bus.rx_d_vld;
  assign rx_last = ({1'b0, rx_idx} + 2'd1) == rsp_len(type_q);

  uart_cmd_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear ((state != WAIT_RSP) || bus.rx_d_vld),
    .enable(state == WAIT_RSP),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SEND;
      SEND:     if (tx_fire && tx_last)
                  state_nxt = (rsp_len(type_q) != 2'd0) ? WAIT_RSP : DONE;
      WAIT_RSP: if (rx_take && rx_last) state_nxt = DONE;
                else if (expire)        state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Protocol byte for the current index; ADDR and FUNC are zero-extended to a full byte.
  always_comb begin
    tx_byte = '0;
    case (type_q)
      CMD_WR:
        case (tx_idx)
          2'd0:    tx_byte = D_WIDTH'(OP_WR);
          2'd1:    tx_byte = D_WIDTH'(addr_q);
          default: tx_byte = wdata_q;
        endcase
      CMD_RD:
        tx_byte = (tx_idx == 2'd0) ? D_WIDTH'(OP_RD) : D_WIDTH'(addr_q);
      CMD_ALU_OPS:
        case (tx_idx)
          2'd0:    tx_byte = D_WIDTH'(OP_ALU_OPS);
          2'd1:    tx_byte = wdata_q;
          2'd2:    tx_byte = opb_q;
          default: tx_byte = D_WIDTH'(func_q);
        endcase
      default:
        tx_byte = (tx_idx == 2'd0) ? D_WIDTH'(OP_ALU) : D_WIDTH'(func_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      resp_q    <= '0;
      type_q    <= CMD_WR;
      addr_q    <= '0;
      wdata_q   <= '0;
      opb_q     <= '0;
      func_q    <= '0;
      tx_idx    <= '0;
      rx_idx    <= 1'b0;
    end else begin
      ready_q   <= (state_nxt == IDLE);
      valid_q   <= (state_nxt == DONE);
      timeout_q <= expire;
      if (accept) begin
        type_q  <= cmd_type_e'(bus.cmd_type);
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        opb_q   <= bus.cmd_opb;
        func_q  <= bus.cmd_func;
        tx_idx  <= '0;
        rx_idx  <= 1'b0;
        resp_q  <= '0;
      end
      if (tx_fire) tx_idx <= tx_idx + 2'd1;
      if (rx_take) begin
        if (rx_idx) resp_q[2*D_WIDTH-1:D_WIDTH] <= bus.rx_p_data;
        else        resp_q[D_WIDTH-1:0]         <= bus.rx_p_data;
        rx_idx <= 1'b1;
      end
      if (expire) resp_q <= '0;
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.tx_d_vld     = (state == SEND);
  assign bus.tx_p_data    = (state == SEND) ? tx_byte : '0;
  assign bus.resp_data    = resp_q;
  assign bus.resp_valid   = valid_q;
  assign bus.resp_timeout = timeout_q;
  assign bus.busy         = (state != IDLE);

`ifdef STRAY_CNT_EN
  logic [7:0] stray_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stray_q <= '0;
    end else if (bus.rx_d_vld && state != WAIT_RSP && stray_q != 8'hFF) begin
      stray_q <= stray_q + 8'd1;
    end
  end

  assign stray_cnt = stray_q;
`else
  // RX strobes outside WAIT_RSP never reach rx_take and are dropped.
`endif

endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
Host-side initiator for the UART register/ALU command protocol. It runs on the host end of the serial link, opposite the system controller.
- Accepts one command per handshake and serialises it into the protocol byte sequence on a byte-wide TX interface.
- Collects the 1- or 2-byte reply from a byte-wide RX interface and presents it as one 16-bit response.
- Guards each reply with a cycle timeout.
- Sits between a test/host sequencer and a UART TX/RX pair clocked on the same clock.

Parameters:
D_WIDTH, 8, byte width of TX/RX and operand data
ADDRESS, 4, register-file address width
FUNC_ALU, 4, ALU function code width
TIMEOUT_W, 16, width of response timeout counter
TIMEOUT_CYC, 50000, cycles allowed between reply bytes before timeout (must be < 2**TIMEOUT_W)

Ports:
CLK  in  1  block clock
RST  in  1  reset
CMD_VALID  in  1  command request
CMD_READY  out  1  block can accept command (high only in IDLE)
CMD_TYPE  in  2  00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands
CMD_ADDR  in  ADDRESS  register address
CMD_WDATA  in  D_WIDTH  write data, or operand A for type 10
CMD_OPB  in  D_WIDTH  operand B for type 10
CMD_FUNC  in  FUNC_ALU  ALU function
TX_P_DATA  out  D_WIDTH  byte to UART TX
TX_D_VLD  out  1  byte valid
TX_READY  in  1  UART TX accepts byte
RX_P_DATA  in  D_WIDTH  received byte
RX_D_VLD  in  1  one-cycle received-byte strobe
RESP_DATA  out  2*D_WIDTH  assembled response
RESP_VALID  out  1  one-cycle response strobe
RESP_TIMEOUT  out  1  one-cycle timeout strobe
BUSY  out  1  high whenever state != IDLE

Reset and clocking (already decided): one clock CLK; RST is synchronous, active-high. All outputs reset to 0. State resets to IDLE. CMD_READY is 1 one cycle after RST deasserts.

Behaviour:
- Command capture: command accepted when CMD_VALID && CMD_READY. All fields are registered at that point, and inputs are then ignored until IDLE.
- Byte sequences (ADDR and FUNC zero-extended to D_WIDTH):
  - type 00: 0xAA, ADDR, WDATA; expects 0 reply bytes
  - type 01: 0xBB, ADDR; expects 1 reply byte
  - type 10: 0xCC, WDATA, OPB, FUNC; expects 2 reply bytes
  - type 11: 0xDD, FUNC; expects 2 reply bytes
- State IDLE -> SEND on accept. TX_D_VLD rises the cycle after accept.
- SEND:
  - A byte transfers on the cycle TX_D_VLD && TX_READY. The index increments and the next byte is presented the following cycle with no bubble.
  - TX_P_DATA is held stable while TX_D_VLD && !TX_READY.
  - After the last byte transfers: go to WAIT_RSP if the expected reply count > 0, otherwise go to DONE.
- WAIT_RSP:
  - Each RX_D_VLD captures RX_P_DATA. The first byte goes to RESP_DATA[7:0]; the second goes to [15:8]. The upper byte is 0 for reads.
  - When the last expected byte arrives -> DONE.
- DONE: RESP_VALID=1 for exactly one cycle, with RESP_DATA stable that cycle; then -> IDLE. Writes return RESP_DATA=0.
- Timeout:
  - The counter clears on entry to WAIT_RSP and on every RX byte, and increments otherwise.
  - When it reaches TIMEOUT_CYC-1: RESP_TIMEOUT=1 for one cycle, RESP_VALID stays 0, the partial response is discarded, and the state goes to IDLE.
  - If an RX byte arrives in the same cycle the threshold is reached, the byte wins and the counter clears.
- RX bytes arriving in IDLE, SEND or DONE are ignored.
- RST asserted mid-operation aborts immediately: TX_D_VLD drops on the next edge, and no RESP_VALID or RESP_TIMEOUT is issued.
- Latency, read with TX_READY always 1: first byte on cycle 1, last TX byte cycle 2, RESP_VALID one cycle after the reply byte.

Optional Feature:
STRAY_CNT_EN:
- Defined: adds output STRAY_CNT [7:0], reset 0. It increments on every RX_D_VLD outside WAIT_RSP and saturates at 255.
- Undefined: port and logic absent; stray bytes are silently dropped.

Decomposition:
- Package uart_cmd_pkg: opcode constants (0xAA, 0xBB, 0xCC, 0xDD), CMD_TYPE encodings, state encoding (IDLE, SEND, WAIT_RSP, DONE), per-type TX length and reply-length constants.
- One sub-module, uart_cmd_timer: parameterised TIMEOUT_W/TIMEOUT_CYC counter with clear/enable inputs and an expire pulse output.

Test Plan:
- Write: type 00, ADDR=3, WDATA=0x5A, TX_READY=1 -> TX bytes AA,03,5A on 3 consecutive cycles; RESP_VALID with RESP_DATA=0x0000; no RX needed.
- Read: type 01, ADDR=2; reply RX 0x81 -> TX AA-free sequence BB,02; RESP_DATA=0x0081 one cycle after RX strobe.
- ALU with operands: type 10, A=0x12, B=0x34, FUNC=0 -> TX CC,12,34,00; replies 0x46 then 0x00 -> RESP_DATA=0x0046.
- Back-pressure: type 11, FUNC=2, TX_READY low for 5 cycles per byte -> TX_P_DATA stable (DD, then 02) while stalled; exactly 2 bytes transferred.
- Timeout: type 01 with no reply, TIMEOUT_CYC=20 -> RESP_TIMEOUT pulse exactly 20 cycles after WAIT_RSP entry, no RESP_VALID, CMD_READY high the next cycle. Repeat with RX arriving on the threshold cycle -> response completes, no timeout.
- Reset mid-SEND after 2 of 4 bytes -> TX_D_VLD=0 and state IDLE after the RST edge; a following read completes normally. With STRAY_CNT_EN, 3 RX strobes in IDLE -> STRAY_CNT=3.
